aes_ark_loader: RTL and testbench
=================================

# aes_ark_loader

Parametrised block-ingest stage for the AES datapath. Accepts a 128-bit key and a stream of 128-bit plaintext blocks as byte-lane beats of configurable width. Holds the key across blocks and emits each block already XORed with the key (initial AddRoundKey), with the key alongside, to the round engine over a valid/ready handshake. Sits between the host byte interface and the round logic.

## Interface
- BEAT_BYTES, 1: bytes per input beat; legal values 1, 2, 4, 8, 16.
- COUNT_W, 16: width of the emitted-block counter.

- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  reset; asynchronous, active-high.
- key_valid  in  1  key beat present.
- key_ready  out  1  key beat accepted when key_valid && key_ready.
- key_data  in  8*BEAT_BYTES  key bytes; byte lane i = key byte (beat*BEAT_BYTES + i), lane 0 in bits [7:0].
- pt_valid  in  1  plaintext beat present.
- pt_ready  out  1  plaintext beat accepted when pt_valid && pt_ready.
- pt_data  in  8*BEAT_BYTES  plaintext bytes, same lane mapping as key_data.
- out_valid  out  1  out_state/out_key valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_state  out  128  plaintext ^ key; byte 0 in [7:0], byte 15 in [127:120].
- out_key  out  128  key used for this block, same byte order.
- key_loaded  out  1  a complete key is held.
- blk_count  out  COUNT_W  blocks emitted since reset; wraps to 0.

## Operation
- Beats per block: NB = 16/BEAT_BYTES. Separate beat counters key_cnt, pt_cnt, each 0..NB-1, wrap to 0 after the final beat.
- Key load:
  - First beat (key_cnt==0) clears key_loaded.
  - Each beat writes its bytes into the key register.
  - Final beat sets key_loaded.
  - A partially loaded key is never used.
- key_ready = (pt_cnt==0) && !pt_full && !out_valid. The key cannot change while any block is in flight or pending.
- pt_ready = key_loaded && (key_cnt==0) && !pt_full.
- Plaintext beats fill a 16-byte staging buffer.
- On the final beat (pt_cnt==NB-1) of a block:
  - If the output register is free, or freeing this cycle (out_valid && out_ready), write out_state = {staged bytes, final beat} ^ key and out_key = key. out_valid is set at that edge.
  - Otherwise set pt_full and hold the block.
- pt_full with the output free or freeing: transfer to the output register, clear pt_full.
- blk_count increments on every out handshake.
- State machine: EMPTY (no key) -> KEYED on final key beat. KEYED -> LOADING on first pt beat (NB>1) or directly to emit (NB=1). Returns to KEYED when pt_cnt wraps. Any new key beat from KEYED returns to EMPTY.
- No keyed block is ever dropped or duplicated. Output holds stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_state=0, out_key=0.
  - key_loaded=0, blk_count=0, key_cnt=pt_cnt=0, pt_full=0.
  - key_ready=1, pt_ready=0.
- Latency: out_valid rises one cycle after the final-beat handshake when the output register is free.
- Throughput: one block per NB cycles with out_ready held 1. BEAT_BYTES=16 sustains one block per cycle.
- Backpressure depth: one block in the output register plus one in the staging buffer. pt_ready drops only when both are full.
- Simultaneous out handshake and final pt beat: new block lands in the output register at the same edge; out_valid stays 1.
- Reset mid-load: all partial key/plaintext discarded; return to reset values asynchronously.
- blk_count wraps from 2^COUNT_W-1 to 0.

## Test plan
- FIPS-197 vector: BEAT_BYTES=1, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_state bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 (byte 0 first). out_key equals the key. out_valid rises one cycle after the 16th pt beat.
- Same vector at BEAT_BYTES=16, out_ready=1, 8 back-to-back blocks -> 8 outputs on consecutive cycles, blk_count=8.
- Backpressure: BEAT_BYTES=4, out_ready=0, send 3 blocks -> first in output, second staged, pt_ready=0 during third. Release out_ready -> blocks emerge in order, unaltered.
- Gating: pt_valid before key load -> pt_ready=0, nothing accepted. A key beat while out_valid=1 -> key_ready=0 until the output drains.
- Rekey: load key A, emit block, load key 000102...0f, emit pt all-zero -> out_state=000102...0f.
- Async reset asserted after 7 of 16 pt beats -> outputs at reset values immediately. After release, key_loaded=0 and a full fresh key+block load produces the correct result.

Source files
------------

// File: rtl/aes_ark_loader.sv
// rtl/aes_ark_loader.sv - AES block ingest with initial AddRoundKey
//
// Collects a 128-bit key and 128-bit plaintext blocks from byte-lane beats
// of BEAT_BYTES bytes. Each block is emitted XORed with the held key, with
// the key alongside, over a valid/ready handshake.
//
// Ports:
//   sys_clk, sys_rst               clock, asynchronous active-high reset
//   key_valid/key_ready/key_data   key beat input (lane i = byte beat*BEAT_BYTES+i)
//   pt_valid/pt_ready/pt_data      plaintext beat input, same lane mapping
//   out_valid/out_ready            output handshake
//   out_state, out_key             plaintext^key and the key used (byte 0 in [7:0])
//   key_loaded                     a complete key is held
//   blk_count                      blocks emitted since reset, wrapping
module aes_ark_loader #(
    parameter int BEAT_BYTES = 1,
    parameter int COUNT_W    = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic [8*BEAT_BYTES-1:0] key_data,
    input  logic                    pt_valid,
    output logic                    pt_ready,
    input  logic [8*BEAT_BYTES-1:0] pt_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_state,
    output logic [127:0]            out_key,
    output logic                    key_loaded,
    output logic [COUNT_W-1:0]      blk_count
);
    localparam int NB = 16 / BEAT_BYTES;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {EMPTY, KEYED, LOADING} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        key_cnt_q, key_cnt_d;
    logic [CW-1:0]        pt_cnt_q, pt_cnt_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         stage_q, stage_d;
    logic                 pt_full_q, pt_full_d;
    logic                 out_valid_q, out_valid_d;
    logic [127:0]         out_state_q, out_state_d;
    logic [127:0]         out_key_q, out_key_d;
    logic [COUNT_W-1:0]   blk_count_q, blk_count_d;

    logic         key_fire, key_last, pt_fire, pt_last, out_fire, out_free;
    logic [127:0] blk_full;

    // Replace the beat-sized lane group selected by idx.
    function automatic logic [127:0] put_beat(input logic [127:0] base,
                                              input logic [CW-1:0] idx,
                                              input logic [8*BEAT_BYTES-1:0] beat);
        logic [127:0] r;
        r = base;
        for (int b = 0; b < NB; b++) begin
            if (idx == CW'(b)) r[b*8*BEAT_BYTES +: 8*BEAT_BYTES] = beat;
        end
        return r;
    endfunction

    assign key_loaded = (state_q != EMPTY);
    assign key_ready  = (pt_cnt_q == '0) && !pt_full_q && !out_valid_q;
    assign pt_ready   = key_loaded && (key_cnt_q == '0) && !pt_full_q;

    assign key_fire = key_valid && key_ready;
    assign key_last = key_fire && (key_cnt_q == LAST);
    assign pt_fire  = pt_valid && pt_ready;
    assign pt_last  = pt_fire && (pt_cnt_q == LAST);
    assign out_fire = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_fire;
    assign blk_full = put_beat(stage_q, pt_cnt_q, pt_data);

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_key   = out_key_q;
    assign blk_count = blk_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (key_last) state_d = KEYED;
            KEYED: begin
                // A fresh key beat invalidates the held key until it completes.
                if (key_fire)     state_d = key_last ? KEYED : EMPTY;
                else if (pt_fire) state_d = pt_last ? KEYED : LOADING;
            end
            LOADING: if (pt_last) state_d = KEYED;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        key_cnt_d   = key_cnt_q;
        pt_cnt_d    = pt_cnt_q;
        key_d       = key_q;
        stage_d     = stage_q;
        pt_full_d   = pt_full_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_key_d   = out_key_q;
        blk_count_d = blk_count_q;

        if (key_fire) begin
            key_d     = put_beat(key_q, key_cnt_q, key_data);
            key_cnt_d = (key_cnt_q == LAST) ? '0 : key_cnt_q + CW'(1);
        end
        if (pt_fire) begin
            stage_d  = blk_full;
            pt_cnt_d = (pt_cnt_q == LAST) ? '0 : pt_cnt_q + CW'(1);
        end
        if (out_fire) blk_count_d = blk_count_q + COUNT_W'(1);

        // pt_full blocks pt_ready, so a staged block and a final beat never coincide.
        if (pt_full_q && out_free) begin
            out_valid_d = 1'b1;
            out_state_d = stage_q ^ key_q;
            out_key_d   = key_q;
            pt_full_d   = 1'b0;
        end else if (pt_last) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_state_d = blk_full ^ key_q;
                out_key_d   = key_q;
            end else begin
                pt_full_d   = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= EMPTY;
            key_cnt_q   <= '0;
            pt_cnt_q    <= '0;
            key_q       <= '0;
            stage_q     <= '0;
            pt_full_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_key_q   <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            pt_cnt_q    <= pt_cnt_d;
            key_q       <= key_d;
            stage_q     <= stage_d;
            pt_full_q   <= pt_full_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_key_q   <= out_key_d;
            blk_count_q <= blk_count_d;
        end
    end
endmodule

// File: tb/tb_aes_ark_loader.sv
// tb/tb_aes_ark_loader.sv - self-checking bench for aes_ark_loader
module tb_aes_ark_loader;
    localparam int ND = 3;
    localparam logic [127:0] FK = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FP = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] FO = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] KB = 128'h0f0e0d0c0b0a09080706050403020100;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic         key_valid [ND];
    logic         key_ready [ND];
    logic [127:0] key_data  [ND];
    logic         pt_valid  [ND];
    logic         pt_ready  [ND];
    logic [127:0] pt_data   [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] out_state [ND];
    logic [127:0] out_key   [ND];
    logic         key_loaded[ND];
    logic [15:0]  blk_count [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int BB = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int CW = (g == 2) ? 4 : 16;
        logic [CW-1:0] bc;
        aes_ark_loader #(.BEAT_BYTES(BB), .COUNT_W(CW)) u_dut (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key_valid (key_valid[g]),
            .key_ready (key_ready[g]),
            .key_data  (key_data[g][8*BB-1:0]),
            .pt_valid  (pt_valid[g]),
            .pt_ready  (pt_ready[g]),
            .pt_data   (pt_data[g][8*BB-1:0]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .out_key   (out_key[g]),
            .key_loaded(key_loaded[g]),
            .blk_count (bc)
        );
        assign blk_count[g] = 16'(bc);
    end

    // Behavioural model: the last complete key per DUT, and a FIFO of blocks
    // that must emerge in order.
    logic [127:0] mkey [ND];
    logic [255:0] expq [ND][$];
    logic [15:0]  mcnt [ND];
    int           mode [ND];   // 0 random out_ready, 1 always ready, 2 never ready
    int           tests = 0;
    int           fails = 0;
    bit           gaps  = 1'b0;

    function automatic int bb_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 16);
    endfunction

    function automatic logic [15:0] mask_of(input int d);
        return (d == 2) ? 16'h000f : 16'hffff;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic align();
        @(posedge sys_clk);
        #1;
    endtask

    // Send beats first..last of a key or plaintext block; the model is
    // updated only when the final beat of the block is accepted.
    task automatic send(input int d, input bit is_key, input logic [127:0] v,
                        input int first, input int last_b);
        int bb;
        int n;
        bb = bb_of(d);
        for (int i = first; i <= last_b; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) align();
            if (is_key) begin
                key_data[d]  = v >> (i * 8 * bb);
                key_valid[d] = 1'b1;
            end else begin
                pt_data[d]  = v >> (i * 8 * bb);
                pt_valid[d] = 1'b1;
            end
            n = 0;
            while (!(is_key ? key_ready[d] : pt_ready[d]) && n < 500) begin
                align();
                n++;
            end
            if (n >= 500) begin
                tests++;
                fails++;
                $display("FAIL handshake_timeout dut%0d key=%0d got=stalled exp=accept", d, is_key);
                key_valid[d] = 1'b0;
                pt_valid[d]  = 1'b0;
                return;
            end
            align();
            key_valid[d] = 1'b0;
            pt_valid[d]  = 1'b0;
        end
        if (last_b == 16 / bb - 1) begin
            if (is_key) mkey[d] = v;
            else        expq[d].push_back({mkey[d], v ^ mkey[d]});
        end
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("reset_flags%0d", d),
            {out_valid[d], key_loaded[d], key_ready[d], pt_ready[d]}, 4'b0010);
        chk($sformatf("reset_out%0d", d), {out_key[d], out_state[d]}, '0);
        chk($sformatf("reset_cnt%0d", d), blk_count[d], 16'd0);
    endtask

    task automatic drain();
        int n;
        for (int d = 0; d < ND; d++) mode[d] = 1;
        n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 300) begin
            align();
            n++;
        end
        align();
        for (int d = 0; d < ND; d++)
            chk($sformatf("drained%0d", d), expq[d].size(), 0);
    endtask

    // FIPS-197 vector on the byte-wide instance, including the latency edge.
    task automatic fips_dut0(input string tag);
        gaps = 1'b0;
        mode[0] = 1;
        send(0, 1'b1, FK, 0, 15);
        chk({tag, "_key_loaded"}, key_loaded[0], 1'b1);
        send(0, 1'b0, FP, 0, 14);
        chk({tag, "_pre_last"}, out_valid[0], 1'b0);
        send(0, 1'b0, FP, 15, 15);
        chk({tag, "_lat"}, out_valid[0], 1'b1);
        chk({tag, "_state"}, out_state[0], FO);
        chk({tag, "_key"}, out_key[0], FK);
    endtask

    task automatic rand_traffic(input int d, input int nblk);
        for (int k = 0; k < nblk; k++) begin
            if (k % 4 == 0) send(d, 1'b1, rnd128(), 0, 16 / bb_of(d) - 1);
            send(d, 1'b0, rnd128(), 0, 16 / bb_of(d) - 1);
        end
    endtask

    // out_ready driver, away from both edges.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            for (int d = 0; d < ND; d++)
                out_ready[d] = (mode[d] == 1) ? 1'b1 :
                               (mode[d] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every falling edge, each output against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("blk_count%0d", d), blk_count[d], mcnt[d]);
                    if (out_valid[d]) begin
                        if (expq[d].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_out%0d got=%h exp=none", d, out_state[d]);
                        end else begin
                            chk($sformatf("out%0d", d), {out_key[d], out_state[d]}, expq[d][0]);
                            if (out_ready[d]) begin
                                void'(expq[d].pop_front());
                                mcnt[d] = (mcnt[d] + 16'd1) & mask_of(d);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            key_valid[d] = 1'b0; key_data[d] = '0;
            pt_valid[d]  = 1'b0; pt_data[d]  = '0;
            out_ready[d] = 1'b0; mode[d]     = 1;
            mkey[d]      = '0;   mcnt[d]     = '0;
        end
        #3;
        for (int d = 0; d < ND; d++) chk_reset(d);
        @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        align();

        // Gating: plaintext offered before any key is never taken.
        pt_data[1]  = rnd128();
        pt_valid[1] = 1'b1;
        repeat (4) begin
            chk("gate_pt_ready", pt_ready[1], 1'b0);
            align();
        end
        pt_valid[1] = 1'b0;

        fips_dut0("fips");
        align();

        // Full-width beats: 8 blocks on 8 consecutive cycles.
        gaps = 1'b0;
        send(2, 1'b1, FK, 0, 0);
        pt_data[2]  = FP;
        pt_valid[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_pt_ready", pt_ready[2], 1'b1);
            expq[2].push_back({FK, FP ^ FK});
            align();
            chk("b2b_out_valid", out_valid[2], 1'b1);
        end
        pt_valid[2] = 1'b0;
        align();
        chk("b2b_idle", out_valid[2], 1'b0);
        chk("b2b_count", blk_count[2], 16'd8);

        // Backpressure: output + staging full stalls the third block and any key.
        mode[1] = 2;
        align();
        align();
        gaps = 1'b1;
        send(1, 1'b1, rnd128(), 0, 3);
        send(1, 1'b0, rnd128(), 0, 3);
        send(1, 1'b0, rnd128(), 0, 3);
        pt_data[1]  = rnd128();
        pt_valid[1] = 1'b1;
        repeat (4) begin
            chk("bp_pt_ready", pt_ready[1], 1'b0);
            align();
        end
        pt_valid[1] = 1'b0;
        key_data[1]  = rnd128();
        key_valid[1] = 1'b1;
        repeat (3) begin
            chk("bp_key_ready", key_ready[1], 1'b0);
            chk("bp_out_valid", out_valid[1], 1'b1);
            align();
        end
        key_valid[1] = 1'b0;
        mode[1] = 1;
        send(1, 1'b0, rnd128(), 0, 3);
        drain();

        // Rekey: key A with a block, then key 00..0f with an all-zero block.
        send(0, 1'b1, rnd128(), 0, 15);
        send(0, 1'b0, rnd128(), 0, 15);
        send(0, 1'b1, KB, 0, 15);
        mode[0] = 2;
        align();
        align();
        send(0, 1'b0, '0, 0, 15);
        chk("rekey_state", out_state[0], KB);
        chk("rekey_key", out_key[0], KB);
        drain();

        // Asynchronous reset after 7 of 16 plaintext beats.
        gaps = 1'b0;
        send(0, 1'b1, FK, 0, 15);
        send(0, 1'b0, FP, 0, 6);
        #1 sys_rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk_reset(d);
            expq[d].delete();
            mcnt[d] = '0;
        end
        @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        align();
        chk("post_reset_key_loaded", key_loaded[0], 1'b0);
        fips_dut0("after_reset");
        drain();

        // Randomized traffic on all three widths in parallel.
        gaps = 1'b1;
        for (int d = 0; d < ND; d++) mode[d] = 0;
        fork
            rand_traffic(0, 12);
            rand_traffic(1, 16);
            rand_traffic(2, 30);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
